// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and JEDEC helpers for the SPI flash responder.
// SPI_RESP_FASTREAD_EN adds the DUMMY state used by the 0x0B fast-read command.
package spi_flash_pkg;

    localparam logic [7:0]  OP_READ          = 8'h03;
    localparam logic [7:0]  OP_FREAD         = 8'h0B;
    localparam logic [7:0]  OP_RDID          = 8'h9F;
    localparam logic [7:0]  OP_RDSR1         = 8'h05;
    localparam logic [7:0]  STATUS_BYTE      = 8'h00;
    localparam logic [23:0] DEFAULT_JEDEC_ID = 24'hEF4016;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
`ifdef SPI_RESP_FASTREAD_EN
        , ST_DUMMY
`endif
    } state_t;

    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_JEDEC,
        SRC_STATUS
    } src_t;

    // Byte idx of the ID, most significant first; past the third byte the master reads zeros.
    function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            2'd2:    return id[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the asynchronous SPI pins plus single-cycle
// SCK rise/fall and chip-select fall/rise pulses, all in the MCLK domain.
module spi_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ncs_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic ncs_o,
    output logic mosi_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic ncs_fall_o,
    output logic ncs_rise_o
);

    logic ncs_meta_q, ncs_q, ncs_prev_q;
    logic sck_meta_q, sck_q, sck_prev_q;
    logic mosi_meta_q, mosi_q;

    // Chip select resets to its idle (deasserted) level so reset release never fakes a fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ncs_meta_q  <= 1'b1;
            ncs_q       <= 1'b1;
            ncs_prev_q  <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_q       <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            ncs_meta_q  <= ncs_i;
            ncs_q       <= ncs_meta_q;
            ncs_prev_q  <= ncs_q;
            sck_meta_q  <= sck_i;
            sck_q       <= sck_meta_q;
            sck_prev_q  <= sck_q;
            mosi_meta_q <= mosi_i;
            mosi_q      <= mosi_meta_q;
        end
    end

    assign ncs_o      = ncs_q;
    assign mosi_o     = mosi_q;
    assign sck_rise_o = sck_q & ~sck_prev_q;
    assign sck_fall_o = ~sck_q & sck_prev_q;
    assign ncs_fall_o = ~ncs_q & ncs_prev_q;
    assign ncs_rise_o = ncs_q & ~ncs_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 read-only flash responder (READ, RDID, RDSR1) backed by a memory read port.
// Define SPI_RESP_FASTREAD_EN to also accept FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          AW       = 22,
    parameter int          MEM_LAT  = 1,
    parameter logic [23:0] JEDEC_ID = DEFAULT_JEDEC_ID
) (
    input  logic          MCLK,
    input  logic          nRESET,
    input  logic          nCS,
    input  logic          CLK,
    input  logic          MOSI,
    output logic          MISO,
    output logic          MISO_OE,
    output logic [AW-1:0] MEMADDR,
    output logic          MEMRD,
    input  logic [7:0]    MEMDATA,
    output logic          BUSY
);

    logic ncs_s, mosi_s, sck_rise, sck_fall, ncs_fall, ncs_rise;

    spi_sync_edge u_sync (
        .clk_i      (MCLK),
        .rst_ni     (nRESET),
        .ncs_i      (nCS),
        .sck_i      (CLK),
        .mosi_i     (MOSI),
        .ncs_o      (ncs_s),
        .mosi_o     (mosi_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .ncs_fall_o (ncs_fall),
        .ncs_rise_o (ncs_rise)
    );

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [23:0]        addr_q, addr_d;
    logic [7:0]         tx_q, tx_d;
    logic [1:0]         id_idx_q, id_idx_d;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic               memrd_q, memrd_d;
    logic [AW-1:0]      memaddr_q, memaddr_d;
    logic [MEM_LAT-1:0] rd_pipe_q, rd_pipe_d;

    // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        id_idx_d  = id_idx_q;
        miso_d    = miso_q;
        memrd_d   = 1'b0;
        memaddr_d = memaddr_q;
        rd_pipe_d = MEM_LAT'({rd_pipe_q, memrd_q});

        if (rd_pipe_q[MEM_LAT-1] && src_q == SRC_MEM) tx_d = MEMDATA;
        if (sck_fall && state_q == ST_DATA) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 5'd0;
                end
            end
            ST_CMD: begin
                if (sck_rise) begin
                    shift_d   = {shift_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        case (shift_d)
                            OP_READ: state_d = ST_ADDR;
`ifdef SPI_RESP_FASTREAD_EN
                            OP_FREAD: state_d = ST_ADDR;
`endif
                            OP_RDID: begin
                                state_d  = ST_DATA;
                                src_d    = SRC_JEDEC;
                                tx_d     = jedec_byte(JEDEC_ID, 2'd0);
                                id_idx_d = 2'd1;
                            end
                            OP_RDSR1: begin
                                state_d = ST_DATA;
                                src_d   = SRC_STATUS;
                                tx_d    = STATUS_BYTE;
                            end
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                if (sck_rise) begin
                    addr_d    = {addr_q[22:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        src_d     = SRC_MEM;
                        memaddr_d = addr_d[AW-1:0];
                        memrd_d   = 1'b1;
                        state_d   = ST_DATA;
`ifdef SPI_RESP_FASTREAD_EN
                        if (shift_q == OP_FREAD) state_d = ST_DUMMY;
`endif
                    end
                end
            end
`ifdef SPI_RESP_FASTREAD_EN
            ST_DUMMY: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        state_d   = ST_DATA;
                    end
                end
            end
`endif
            ST_DATA: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        addr_d    = addr_q + 24'd1;
                        case (src_q)
                            SRC_MEM: begin
                                memaddr_d = addr_d[AW-1:0];
                                memrd_d   = 1'b1;
                            end
                            SRC_JEDEC: begin
                                tx_d = jedec_byte(JEDEC_ID, id_idx_q);
                                if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                            end
                            default: tx_d = STATUS_BYTE;
                        endcase
                    end
                end
            end
            default: ;
        endcase

        // Chip-select release aborts whatever is in flight, including a partial byte.
        if (ncs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            memrd_d   = 1'b0;
            rd_pipe_d = '0;
        end

        oe_d = (state_d == ST_DATA);
        if (!oe_d) miso_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            src_q     <= SRC_MEM;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            id_idx_q  <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            memrd_q   <= 1'b0;
            memaddr_q <= '0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            id_idx_q  <= id_idx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            memrd_q   <= memrd_d;
            memaddr_q <= memaddr_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    assign MISO    = miso_q;
    assign MISO_OE = oe_q;
    assign MEMRD   = memrd_q;
    assign MEMADDR = memaddr_q;
    assign BUSY    = ~ncs_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: directed SPI transactions push expected
// MISO bytes and MEMRD addresses; independent monitors pop and compare them.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int AW      = 24;
    localparam int MEM_LAT = 1;
    localparam int HP      = 8;

    logic          mclk = 1'b0;
    logic          nreset, ncs, sck, mosi;
    logic          miso, miso_oe, memrd, busy;
    logic [AW-1:0] memaddr;
    logic [7:0]    memdata = 8'h00;

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_addrs[$];

    always #5 mclk = ~mclk;

    spi_flash_responder #(.AW(AW), .MEM_LAT(MEM_LAT), .JEDEC_ID(24'hEF4016)) dut (
        .MCLK    (mclk),
        .nRESET  (nreset),
        .nCS     (ncs),
        .CLK     (sck),
        .MOSI    (mosi),
        .MISO    (miso),
        .MISO_OE (miso_oe),
        .MEMADDR (memaddr),
        .MEMRD   (memrd),
        .MEMDATA (memdata),
        .BUSY    (busy)
    );

    // Memory model: byte[a] = a[7:0] ^ 0x5A, one cycle after the strobe.
    always @(posedge mclk) if (memrd) memdata <= memaddr[7:0] ^ 8'h5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // MISO monitor: master samples on SCK rise while the responder drives the line.
    initial begin
        int       bits = 0;
        logic [7:0] sr = '0;
        forever begin
            @(posedge sck or posedge ncs);
            if (ncs) bits = 0;
            else if (miso_oe === 1'b1) begin
                sr = {sr[6:0], miso};
                bits++;
                if (bits == 8) begin
                    bits = 0;
                    if (exp_bytes.size() == 0) flag_unexpected("miso_byte", {24'h0, sr});
                    else check("miso_byte", {24'h0, sr}, {24'h0, exp_bytes.pop_front()});
                end
            end
        end
    end

    // MEMRD monitor.
    initial begin
        forever begin
            @(negedge mclk);
            if (memrd === 1'b1) begin
                if (exp_addrs.size() == 0) flag_unexpected("memrd_addr", {8'h0, memaddr});
                else check("memrd_addr", {8'h0, memaddr}, {8'h0, exp_addrs.pop_front()});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_mclk(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic cs_low();
        @(negedge mclk);
        ncs = 1'b0;
        wait_mclk(HP);
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            wait_mclk(HP);
            sck = 1'b1;
            wait_mclk(HP);
            sck = 1'b0;
        end
    endtask

    task automatic cs_high();
        wait_mclk(HP);
        ncs  = 1'b1;
        mosi = 1'b0;
        repeat (3) @(posedge mclk);
        #1 check("oe_after_cs_rise", {31'h0, miso_oe}, 32'h0);
        wait_mclk(4 * HP);
    endtask

    task automatic drain(input string name);
        check({name, "_bytes_left"}, exp_bytes.size(), 32'd0);
        check({name, "_memrd_left"}, exp_addrs.size(), 32'd0);
    endtask

    initial begin
        nreset = 1'b0;
        ncs    = 1'b1;
        sck    = 1'b0;
        mosi   = 1'b0;
        wait_mclk(3);
        check("rst_miso",    {31'h0, miso},    32'h0);
        check("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("rst_memrd",   {31'h0, memrd},   32'h0);
        check("rst_memaddr", {8'h0, memaddr},  32'h0);
        check("rst_busy",    {31'h0, busy},    32'h0);
        nreset = 1'b1;
        wait_mclk(4);

        // RDID: EF 40 16 then zeros.
        exp_bytes = '{8'hEF, 8'h40, 8'h16, 8'h00};
        cs_low();
        check("busy_in_xfer", {31'h0, busy}, 32'h1);
        spi_bits({24'h0, OP_RDID}, 8);
        check("rdid_oe", {31'h0, miso_oe}, 32'h1);
        spi_bits(32'h0, 32);
        cs_high();
        drain("rdid");

        // READ 0x000100, four bytes; the 4th boundary prefetches 0x104.
        exp_addrs = '{24'h000100, 24'h000101, 24'h000102, 24'h000103, 24'h000104};
        exp_bytes = '{8'h5A, 8'h5B, 8'h58, 8'h59};
        cs_low();
        spi_bits({OP_READ, 24'h000100}, 32);
        spi_bits(32'h0, 32);
        cs_high();
        drain("read100");

        // READ across the 24-bit address wrap.
        exp_addrs = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        exp_bytes = '{8'hA4, 8'hA5, 8'h5A};
        cs_low();
        spi_bits({OP_READ, 24'hFFFFFE}, 32);
        spi_bits(32'h0, 24);
        cs_high();
        drain("wrap");

        // Unknown opcode: line stays undriven, no memory access.
        cs_low();
        spi_bits(32'hAB, 8);
        spi_bits(32'h0, 8);
        check("ignore_oe_mid", {31'h0, miso_oe}, 32'h0);
        spi_bits(32'h0, 8);
        check("ignore_oe_end", {31'h0, miso_oe}, 32'h0);
        cs_high();
        drain("ignore");

        // Abort after 12 address bits, then a clean READ of 0x10.
        cs_low();
        spi_bits({24'h0, OP_READ}, 8);
        spi_bits(32'h0, 12);
        cs_high();
        exp_addrs = '{24'h000010, 24'h000011, 24'h000012};
        exp_bytes = '{8'h4A, 8'h4B};
        cs_low();
        spi_bits({OP_READ, 24'h000010}, 32);
        spi_bits(32'h0, 16);
        cs_high();
        drain("abort_then_read");

        // Reset in the middle of the second data byte.
        exp_addrs = '{24'h000040, 24'h000041};
        exp_bytes = '{8'h1A};
        cs_low();
        spi_bits({OP_READ, 24'h000040}, 32);
        spi_bits(32'h0, 12);
        @(negedge mclk);
        nreset = 1'b0;
        #1;
        check("midrst_miso",    {31'h0, miso},    32'h0);
        check("midrst_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("midrst_memrd",   {31'h0, memrd},   32'h0);
        check("midrst_memaddr", {8'h0, memaddr},  32'h0);
        check("midrst_busy",    {31'h0, busy},    32'h0);
        ncs = 1'b1;
        wait_mclk(4);
        nreset = 1'b1;
        wait_mclk(4 * HP);
        drain("midrst");
        exp_addrs = '{24'h000055, 24'h000056};
        exp_bytes = '{8'h0F};
        cs_low();
        spi_bits({OP_READ, 24'h000055}, 32);
        spi_bits(32'h0, 8);
        cs_high();
        drain("after_rst");

`ifdef SPI_RESP_FASTREAD_EN
        // FAST READ 0x000020 with 8 dummy clocks.
        exp_addrs = '{24'h000020, 24'h000021, 24'h000022};
        exp_bytes = '{8'h7A, 8'h7B};
        cs_low();
        spi_bits({OP_FREAD, 24'h000020}, 32);
        spi_bits(32'h0, 4);
        check("dummy_oe", {31'h0, miso_oe}, 32'h0);
        spi_bits(32'h0, 4);
        spi_bits(32'h0, 16);
        cs_high();
        drain("fastread");
`else
        // Without fast read, 0x0B is just another unknown opcode.
        cs_low();
        spi_bits({OP_FREAD, 24'h000020}, 32);
        check("fread_off_oe", {31'h0, miso_oe}, 32'h0);
        spi_bits(32'h0, 16);
        cs_high();
        drain("fread_off");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
